// File: rtl/fmap_rd_stream.sv
// Burst reader: streams a run of SRAM words, in address order, into a
// 2-entry output FIFO with ready/valid backpressure.
module fmap_rd_stream #(
  parameter int DW = 64,
  parameter int AW = 12,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [MW-1:0] sram_wem,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_r;
  logic [AW-1:0] rd_addr_r;
  logic [AW-1:0] last_addr_r;
  logic [AW:0]   issue_cnt_r;
  logic [AW:0]   out_cnt_r;
  logic          inflight_r;
  logic          busy_r;
  logic          done_r;
  logic [DW-1:0] head_r;
  logic [DW-1:0] tail_r;
  logic [1:0]    fifo_cnt_r;

  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [2:0]    credit_s;

  // Issue decision: a read may go out only if its word is guaranteed a FIFO slot.
  always_comb begin
    pop_s    = 1'b0;
    issue_s  = 1'b0;
    credit_s = 3'd0;
    pop_s    = (fifo_cnt_r != 2'd0) && out_ready;
    credit_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    if ((state_r == RUN) && (issue_cnt_r != CNT_ZERO) && (credit_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign push_s    = inflight_r;
  assign sram_cs   = issue_s;
  assign sram_addr = issue_s ? rd_addr_r : last_addr_r;
  assign sram_we   = 1'b0;
  assign sram_wem  = {MW{1'b0}};
  assign out_valid = (fifo_cnt_r != 2'd0);
  assign out_data  = head_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Burst control FSM, address/count bookkeeping and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rd_addr_r   <= {AW{1'b0}};
      last_addr_r <= {AW{1'b0}};
      issue_cnt_r <= CNT_ZERO;
      out_cnt_r   <= CNT_ZERO;
      inflight_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      inflight_r <= issue_s;
      if (issue_s) begin
        rd_addr_r   <= rd_addr_r + ADDR_ONE;
        last_addr_r <= rd_addr_r;
        issue_cnt_r <= issue_cnt_r - CNT_ONE;
      end
      if (pop_s) begin
        out_cnt_r <= out_cnt_r - CNT_ONE;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            if (length != CNT_ZERO) begin
              rd_addr_r   <= base_addr;
              issue_cnt_r <= length;
              out_cnt_r   <= length;
              busy_r      <= 1'b1;
              state_r     <= RUN;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue_s && (issue_cnt_r == CNT_ONE)) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_s && (out_cnt_r == CNT_ONE)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output FIFO: head feeds out_data directly, tail holds the second word.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt_r <= 2'd0;
      head_r     <= {DW{1'b0}};
      tail_r     <= {DW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (fifo_cnt_r == 2'd0) begin
            head_r     <= sram_dout;
            fifo_cnt_r <= 2'd1;
          end else begin
            tail_r     <= sram_dout;
            fifo_cnt_r <= 2'd2;
          end
        end
        2'b01: begin
          head_r     <= tail_r;
          fifo_cnt_r <= fifo_cnt_r - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_r == 2'd1) begin
            head_r <= sram_dout;
          end else begin
            head_r <= tail_r;
            tail_r <= sram_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_rd_stream.sv
// Randomized bench for fmap_rd_stream: SRAM model, expected-word queues and
// cycle-exact latency checks.
module tb_fmap_rd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        busy, done, out_valid, out_ready;
  logic [63:0] out_data;
  logic        sram_cs, sram_we;
  logic [7:0]  sram_wem;
  logic [11:0] sram_addr;
  logic [63:0] sram_dout;

  fmap_rd_stream dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sram_cs(sram_cs), .sram_we(sram_we), .sram_wem(sram_wem),
    .sram_addr(sram_addr), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem [0:4095];
  always @(posedge clk) if (sram_cs) sram_dout <= mem[sram_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  logic [63:0] exp_data_q[$];
  logic [11:0] exp_addr_q[$];
  int cs_log[$], xfer_log[$], done_log[$];
  int issued = 0, popped = 0;
  bit prev_stall = 1'b0;
  logic [63:0] prev_data;
  int t_start;

  // Passive monitor: address order, data order, credit bound, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_data_q.delete();
      exp_addr_q.delete();
      issued = 0;
      popped = 0;
      prev_stall = 1'b0;
    end else begin
      if (sram_cs) begin
        cs_log.push_back(cyc);
        issued++;
        if (exp_addr_q.size() == 0) check("cs_unexpected", 64'd1, 64'd0);
        else check("sram_addr", {52'd0, sram_addr}, {52'd0, exp_addr_q.pop_front()});
      end
      if (out_valid && out_ready) begin
        xfer_log.push_back(cyc);
        popped++;
        if (exp_data_q.size() == 0) check("xfer_unexpected", 64'd1, 64'd0);
        else check("out_data", out_data, exp_data_q.pop_front());
      end
      if (sram_cs) check("credit", {63'd0, (issued - popped) <= 2}, 64'd1);
      if (prev_stall) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) done_log.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    cs_log.delete();
    xfer_log.delete();
    done_log.delete();
  endtask

  task automatic do_start(input logic [11:0] b, input logic [12:0] n, input bit expect_it);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = n; t_start = cyc;
    if (expect_it) begin
      for (int i = 0; i < int'(n); i++) begin
        logic [11:0] a;
        a = b + i[11:0];
        exp_addr_q.push_back(a);
        exp_data_q.push_back(mem[a]);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1 repeating, 2: random
  task automatic wait_done(input int mode);
    bit seen = 1'b0;
    int phase = 0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(posedge clk); #1;
      case (mode)
        1: out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      phase++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic check_burst(input string tag, input int n);
    check({tag, "_xfers"}, xfer_log.size(), n);
    check({tag, "_dones"}, done_log.size(), 64'd1);
    check({tag, "_left"}, exp_data_q.size(), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_done"},  {63'd0, done}, 64'd0);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_cs"},    {63'd0, sram_cs}, 64'd0);
    check({tag, "_we"},    {63'd0, sram_we}, 64'd0);
    check({tag, "_wem"},   {56'd0, sram_wem}, 64'd0);
    check({tag, "_addr"},  {52'd0, sram_addr}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
    rst = 1'b1; start = 1'b0; base_addr = 12'd0; length = 13'd0; out_ready = 1'b1;

    // Reset, with a start held during reset that must be ignored.
    tick(2);
    start = 1'b1; base_addr = 12'h040; length = 13'd5;
    tick(1);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    clear_logs();
    tick(5);
    check("rst_start_cs", cs_log.size(), 64'd0);

    // Streaming latency.
    clear_logs();
    do_start(12'h010, 13'd4, 1'b1);
    wait_done(0);
    tick(2);
    check("stream_cs_cnt", cs_log.size(), 64'd4);
    for (int i = 0; i < 4 && i < cs_log.size(); i++) check("stream_cs_cyc", cs_log[i], t_start + 1 + i);
    for (int i = 0; i < 4 && i < xfer_log.size(); i++) check("stream_xfer_cyc", xfer_log[i], t_start + 3 + i);
    if (done_log.size() > 0) check("stream_done_cyc", done_log[0], t_start + 7);
    check_burst("stream", 4);

    // Address wrap-around.
    clear_logs();
    do_start(12'hFFE, 13'd4, 1'b1);
    wait_done(0);
    tick(2);
    check_burst("wrap", 4);

    // Backpressure pattern.
    clear_logs();
    do_start(12'h0A0, 13'd6, 1'b1);
    wait_done(1);
    tick(2);
    check_burst("bp", 6);

    // Zero-length start.
    clear_logs();
    do_start(12'h123, 13'd0, 1'b0);
    @(negedge clk);
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_busy", {63'd0, busy}, 64'd0);
    tick(3);
    check("zero_cs", cs_log.size(), 64'd0);
    check("zero_dones", done_log.size(), 64'd1);

    // Start during a busy burst is ignored.
    clear_logs();
    do_start(12'h300, 13'd16, 1'b1);
    tick(2);
    start = 1'b1; base_addr = 12'h555; length = 13'd7;
    tick(1);
    start = 1'b0;
    @(negedge clk);
    check("busy_mid", {63'd0, busy}, 64'd1);
    wait_done(0);
    tick(10);
    check_burst("busy_start", 16);

    // Reset during the 5th cycle of a 32-word burst.
    clear_logs();
    do_start(12'h200, 13'd32, 1'b1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    check("midrst_valid2", {63'd0, out_valid}, 64'd0);
    clear_logs();
    do_start(12'h100, 13'd2, 1'b1);
    wait_done(0);
    tick(5);
    check_burst("post_rst", 2);

    // Random bursts with random backpressure.
    for (int r = 0; r < 6; r++) begin
      logic [11:0] b;
      int n;
      b = 12'($urandom_range(0, 4095));
      n = $urandom_range(1, 20);
      clear_logs();
      do_start(b, n[12:0], 1'b1);
      wait_done(2);
      tick(3);
      check_burst("rand", n);
    end

    // Maximum length burst.
    clear_logs();
    do_start(12'($urandom_range(0, 4095)), 13'd4096, 1'b1);
    wait_done(0);
    tick(3);
    check_burst("full", 4096);
    check("full_cs_cnt", cs_log.size(), 64'd4096);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmap_rd_stream.md
FMAP_RD_STREAM -- requirements
Module: fmap_rd_stream

Interface
REQ-001 Parameter DW, default 64, SRAM word width in bits.
REQ-002 Parameter AW, default 12, SRAM address width (4096 words).
REQ-003 Parameter MW, default 8, SRAM byte-write-mask width (DW/8).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin a burst read.
REQ-007 base_addr  input  AW  first word address of the burst, sampled with an accepted start.
REQ-008 length  input  AW+1  number of words to read (0..4096), sampled with an accepted start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse when the burst completes.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  downstream accepts the word; a transfer occurs when out_valid and out_ready are both high.
REQ-013 out_data  output  DW  read word, in address order.
REQ-014 sram_cs  output  1  SRAM chip select, one read issued per high cycle.
REQ-015 sram_we  output  1  SRAM write enable, tied low.
REQ-016 sram_wem  output  MW  SRAM byte write mask, tied to all zeros.
REQ-017 sram_addr  output  AW  SRAM word address.
REQ-018 sram_dout  input  DW  SRAM read data, valid exactly one cycle after a cycle with sram_cs high.

Function
REQ-019 States: IDLE, RUN, DRAIN.
- start accepted only in IDLE.
- start while busy is ignored.
REQ-020 IDLE + start with length>0:
- latch base_addr into rd_addr and length into issue_cnt and out_cnt.
- go to RUN.
REQ-021 IDLE + start with length==0:
- no SRAM access.
- done pulses in the next cycle.
- busy stays low; state stays IDLE.
REQ-022 Buffering:
- 2-entry output FIFO; out_data/out_valid are driven from its head register.
- Exactly one read may be in flight (issued last cycle, data arriving this cycle).
REQ-023 Read issue in RUN:
- condition: issue_cnt>0 and (fifo_occupancy + inflight − pop_this_cycle) < 2.
- on issue: sram_cs=1, sram_addr=rd_addr; then rd_addr increments, issue_cnt decrements.
REQ-024 Address arithmetic is modulo 2^AW: rd_addr 4095 wraps to 0, no error.
REQ-025 Capture: the cycle after an issue, sram_dout is written into the FIFO tail; simultaneous push and pop on a full or one-entry FIFO is legal.
REQ-026 RUN → DRAIN when the last read is issued (issue_cnt reaches 0).
REQ-027 DRAIN → IDLE when the final word transfers (out_cnt reaches 0):
- done=1 in the following cycle.
- busy=0 in that same cycle.
REQ-028 Throughput: with out_ready held high, one word per cycle after first latency.
- Start accepted at cycle T: first sram_cs at T+1, first out_valid at T+3.
- Last word of an N-word burst transfers at T+N+2; done pulses at T+N+3.
REQ-029 Backpressure: out_valid and out_data hold stable while out_ready is low; no word is dropped or duplicated; sram_cs is suppressed when credit is exhausted.
REQ-030 out_data is don't-care when out_valid is low; sram_addr holds its last value when sram_cs is low.

Reset
REQ-031 rst high at a rising edge forces the following, regardless of state, including mid-burst:
- State IDLE.
- busy=0, done=0, out_valid=0.
- sram_cs=0, sram_we=0, sram_wem=0.
- sram_addr=0, FIFO empty, counters 0, in-flight flag cleared.
REQ-032 Read data returning in the cycle after reset is discarded; a start sampled while rst is high is ignored.

Verification
REQ-033 Streaming: base=0x010, length=4, out_ready=1, start at T.
- sram_cs high T+1..T+4 with addr 0x010..0x013.
- Words transfer T+3..T+6 matching preloaded memory; done at T+7.
REQ-034 Wrap-around: base=0xFFE, length=4.
- Addresses issued are 0xFFE, 0xFFF, 0x000, 0x001, in order.
- Data is returned in that same order.
REQ-035 Backpressure: length=6, out_ready toggles 1,0,0,1,…
- All 6 words are delivered exactly once, in order.
- sram_cs never causes FIFO occupancy to exceed 2.
- out_data is stable during every stall.
REQ-036 Zero length and busy start:
- length=0: done pulses one cycle after start, no sram_cs.
- A second start during a 16-word burst is ignored: exactly 16 words, one done.
REQ-037 Reset mid-burst: assert rst during the 5th cycle of a 32-word burst.
- All outputs return to reset values next cycle.
- A subsequent start with base=0x100, length=2 delivers words 0x100 and 0x101 only.
